// File: rtl/alu_arbiter_if.sv
// Bundle of signals between the ALU arbiter, its two requesters and the shared ALU.
// The slave modport is the arbiter's view. The master modport is the view of the
// requesters and the ALU together.
interface alu_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [63:0] resp_result;
  logic [1:0]  resp_branch;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_branch;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready, alu_result, alu_branch,
    input  req_ready, resp_valid, resp_result, resp_branch, alu_op, alu_a, alu_b
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready, alu_result, alu_branch,
    output req_ready, resp_valid, resp_result, resp_branch, alu_op, alu_a, alu_b
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port arbiter for the shared execute-stage ALU.
// Port 0 is the pipeline and port 1 is the auxiliary requester.
// At most one operation is granted per cycle, and the ALU is driven combinationally
// from the granted port. Each result is captured into that port's response buffer,
// which holds it under a valid/ready handshake. If port 1 loses STARVE_MAX
// arbitrations in a row while eligible, it is force-granted.
module alu_arbiter #(
  parameter int unsigned STARVE_MAX = 3
) (
  input logic          clk,
  input logic          rst_n,
  alu_arbiter_if.slave bus
);

  localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

  logic [1:0]        buf_free;
  logic [1:0]        eligible;
  logic [1:0]        grant;
  logic [1:0]        resp_valid_reg;
  logic [1:0][31:0]  resp_result_reg;
  logic [1:0]        resp_branch_reg;
  logic [3:0]        starve_cnt_reg;

  // A buffer may be refilled in the same cycle its response is accepted.
  assign buf_free = ~resp_valid_reg | bus.resp_ready;
  assign eligible = bus.req_valid & buf_free;

  // Fixed priority to port 0, overridden for port 1 once its starve count is exhausted.
  always_comb begin
    grant = 2'b00;
    if (eligible == 2'b11) begin
      grant = (starve_cnt_reg == STARVE_LIMIT) ? 2'b10 : 2'b01;
    end else begin
      grant = eligible;
    end
  end

  // Drive the ALU from the winner. Idle cycles use all zeros, so no branch is flagged.
  always_comb begin
    bus.alu_op = 4'b0000;
    bus.alu_a  = 32'd0;
    bus.alu_b  = 32'd0;
    if (grant[0]) begin
      bus.alu_op = bus.req_op[3:0];
      bus.alu_a  = bus.req_a[31:0];
      bus.alu_b  = bus.req_b[31:0];
    end else if (grant[1]) begin
      bus.alu_op = bus.req_op[7:4];
      bus.alu_a  = bus.req_a[63:32];
      bus.alu_b  = bus.req_b[63:32];
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
      // Per-port response buffer. A grant fills it. An accept without a refill empties it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          resp_valid_reg[gi]  <= 1'b0;
          resp_result_reg[gi] <= 32'd0;
          resp_branch_reg[gi] <= 1'b0;
        end else if (grant[gi]) begin
          resp_valid_reg[gi]  <= 1'b1;
          resp_result_reg[gi] <= bus.alu_result;
          resp_branch_reg[gi] <= bus.alu_branch;
        end else if (bus.resp_ready[gi]) begin
          resp_valid_reg[gi]  <= 1'b0;
        end
      end
    end
  endgenerate

  // Count consecutive losses by an eligible port 1. Clear on a win or when it is not competing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_reg <= 4'd0;
    end else if (grant[1] || !eligible[1]) begin
      starve_cnt_reg <= 4'd0;
    end else if (grant[0]) begin
      starve_cnt_reg <= (starve_cnt_reg >= STARVE_LIMIT) ? STARVE_LIMIT : starve_cnt_reg + 4'd1;
    end
  end

  assign bus.req_ready   = grant;
  assign bus.resp_valid  = resp_valid_reg;
  assign bus.resp_result = resp_result_reg;
  assign bus.resp_branch = resp_branch_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter. It applies a vector table, then runs sequences
// for async reset, counter reset and the starvation pattern.
// The bench models a small ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, C beq, D bne.
module tb_alu_arbiter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  alu_arbiter_if bus();

  alu_arbiter #(.STARVE_MAX(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU, combinational from the arbiter's drive.
  always_comb begin
    bus.alu_result = 32'd0;
    bus.alu_branch = 1'b0;
    case (bus.alu_op)
      4'h0: bus.alu_result = bus.alu_a + bus.alu_b;
      4'h1: bus.alu_result = bus.alu_a - bus.alu_b;
      4'h2: bus.alu_result = bus.alu_a & bus.alu_b;
      4'h3: bus.alu_result = bus.alu_a | bus.alu_b;
      4'h4: bus.alu_result = bus.alu_a ^ bus.alu_b;
      4'hC: bus.alu_branch = (bus.alu_a == bus.alu_b);
      4'hD: bus.alu_branch = (bus.alu_a != bus.alu_b);
      default: ;
    endcase
  end

  typedef struct {
    logic [1:0]  valid;
    logic [7:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  rready;
    logic [1:0]  exp_ready;
    logic [3:0]  exp_alu_op;
    logic [31:0] exp_alu_a;
    logic [31:0] exp_alu_b;
    logic [1:0]  exp_rvalid;
    logic [63:0] exp_result;
    logic [1:0]  exp_branch;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] valid, input logic [7:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [1:0] rready);
    bus.req_valid  = valid;
    bus.req_op     = op;
    bus.req_a      = a;
    bus.req_b      = b;
    bus.resp_ready = rready;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(2'b00, 8'h00, 64'd0, 64'd0, 2'b00);

    //                valid  op     a                      b                      rr     rdy    aop   alu_a         alu_b         rv     result                 br
    vecs[0]  = '{2'b01, 8'h00, 64'h0000_0000_0000_0005, 64'h0000_0000_0000_0007, 2'b00, 2'b01, 4'h0, 32'h5,        32'h7,        2'b01, 64'h0000_0000_0000_000C, 2'b00};
    vecs[1]  = '{2'b10, 8'hC0, 64'h0000_1234_0000_0000, 64'h0000_1234_0000_0000, 2'b00, 2'b10, 4'hC, 32'h1234,     32'h1234,     2'b11, 64'h0000_0000_0000_000C, 2'b10};
    vecs[2]  = '{2'b01, 8'h00, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002, 2'b00, 2'b00, 4'h0, 32'h0,        32'h0,        2'b11, 64'h0000_0000_0000_000C, 2'b10};
    vecs[3]  = '{2'b01, 8'h00, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002, 2'b01, 2'b01, 4'h0, 32'h1,        32'h2,        2'b11, 64'h0000_0000_0000_0003, 2'b10};
    vecs[4]  = '{2'b10, 8'hD0, 64'h0000_1234_0000_0000, 64'h0000_1234_0000_0000, 2'b10, 2'b10, 4'hD, 32'h1234,     32'h1234,     2'b11, 64'h0000_0000_0000_0003, 2'b00};
    vecs[5]  = '{2'b00, 8'h00, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 2'b00, 2'b00, 4'h0, 32'h0,        32'h0,        2'b11, 64'h0000_0000_0000_0003, 2'b00};
    vecs[6]  = '{2'b00, 8'h00, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 2'b11, 2'b00, 4'h0, 32'h0,        32'h0,        2'b00, 64'h0000_0000_0000_0003, 2'b00};
    vecs[7]  = '{2'b00, 8'h00, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 2'b11, 2'b00, 4'h0, 32'h0,        32'h0,        2'b00, 64'h0000_0000_0000_0003, 2'b00};
    vecs[8]  = '{2'b10, 8'h10, 64'h0000_0064_0000_0000, 64'h0000_001E_0000_0000, 2'b00, 2'b10, 4'h1, 32'd100,      32'd30,       2'b10, 64'h0000_0046_0000_0003, 2'b00};
    vecs[9]  = '{2'b11, 8'h12, 64'h0000_0064_0000_F0F0, 64'h0000_001E_0000_FF00, 2'b00, 2'b01, 4'h2, 32'hF0F0,     32'hFF00,     2'b11, 64'h0000_0046_0000_F000, 2'b00};
    vecs[10] = '{2'b11, 8'h14, 64'h0000_0064_0000_00FF, 64'h0000_001E_0000_000F, 2'b11, 2'b01, 4'h4, 32'hFF,       32'h0F,       2'b01, 64'h0000_0046_0000_00F0, 2'b00};

    // Reset state.
    tick();
    tick();
    check("reset_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("reset_resp_result", bus.resp_result, 64'd0);
    check("reset_resp_branch", 64'(bus.resp_branch), 64'd0);
    rst_n = 1'b1;
    tick();

    // Vector table. Drive just after an edge, check the combinational outputs,
    // then check the registered outputs after the next edge.
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].valid, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rready);
      #1;
      check($sformatf("v%0d_req_ready", i), 64'(bus.req_ready), 64'(vecs[i].exp_ready));
      check($sformatf("v%0d_alu_op", i),    64'(bus.alu_op),    64'(vecs[i].exp_alu_op));
      check($sformatf("v%0d_alu_a", i),     64'(bus.alu_a),     64'(vecs[i].exp_alu_a));
      check($sformatf("v%0d_alu_b", i),     64'(bus.alu_b),     64'(vecs[i].exp_alu_b));
      tick();
      check($sformatf("v%0d_resp_valid", i),  64'(bus.resp_valid),  64'(vecs[i].exp_rvalid));
      check($sformatf("v%0d_resp_result", i), bus.resp_result,      vecs[i].exp_result);
      check($sformatf("v%0d_resp_branch", i), 64'(bus.resp_branch), 64'(vecs[i].exp_branch));
      $display("vec %0d: valid=%b ready=%b resp_valid=%b result=%h", i, vecs[i].valid,
               bus.req_ready, bus.resp_valid, bus.resp_result);
    end

    // Async reset while both buffers are full.
    drive(2'b00, 8'h00, 64'd0, 64'd0, 2'b11);
    tick();
    drive(2'b01, 8'h00, 64'h0000_0000_0000_0002, 64'h0000_0000_0000_0003, 2'b00);
    tick();
    drive(2'b10, 8'h10, 64'h0000_0009_0000_0000, 64'h0000_0004_0000_0000, 2'b00);
    tick();
    check("ar_pre_valid", 64'(bus.resp_valid), 64'h3);
    check("ar_pre_result", bus.resp_result, 64'h0000_0005_0000_0005);
    drive(2'b00, 8'h00, 64'd0, 64'd0, 2'b00);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("ar_resp_result", bus.resp_result, 64'd0);
    check("ar_resp_branch", 64'(bus.resp_branch), 64'd0);
    $display("async reset: resp_valid=%b result=%h", bus.resp_valid, bus.resp_result);
    tick();
    rst_n = 1'b1;
    drive(2'b01, 8'h00, 64'h0000_0000_0000_0005, 64'h0000_0000_0000_0007, 2'b00);
    #1;
    check("ar_post_ready", 64'(bus.req_ready), 64'h1);
    tick();
    check("ar_post_valid", 64'(bus.resp_valid), 64'h1);
    check("ar_post_result", 64'(bus.resp_result[31:0]), 64'd12);

    // Build the starve count up to 2, then reset it asynchronously.
    for (int k = 0; k < 2; k++) begin
      drive(2'b11, 8'h10, 64'h0000_0032_0000_000A, 64'h0000_0008_0000_0001, 2'b11);
      #1;
      check($sformatf("pre_starve%0d_ready", k), 64'(bus.req_ready), 64'h1);
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("cr_resp_valid", 64'(bus.resp_valid), 64'd0);
    tick();
    rst_n = 1'b1;

    // Starvation: both ports eligible every cycle. Grants must follow 0,0,0,1 from a cleared counter.
    for (int k = 0; k < 8; k++) begin
      logic [1:0] exp_g;
      exp_g = (k % 4 == 3) ? 2'b10 : 2'b01;
      drive(2'b11, 8'h10, 64'h0000_0032_0000_000A, 64'h0000_0008_0000_0001, 2'b11);
      #1;
      check($sformatf("starve%0d_ready", k), 64'(bus.req_ready), 64'(exp_g));
      tick();
      if (exp_g[1]) begin
        check($sformatf("starve%0d_p1_result", k), 64'(bus.resp_result[63:32]), 64'd42);
        check($sformatf("starve%0d_p1_valid", k), 64'(bus.resp_valid[1]), 64'd1);
      end else begin
        check($sformatf("starve%0d_p0_result", k), 64'(bus.resp_result[31:0]), 64'd11);
        check($sformatf("starve%0d_p0_valid", k), 64'(bus.resp_valid[0]), 64'd1);
      end
      $display("starve cycle %0d: expected grant=%b resp_valid=%b", k, exp_g, bus.resp_valid);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
